// File: rtl/dtc_master_rx_if.sv
// Serial readout input and word-stream output of the master-side DTC receiver.
// The slave modport is the receiver; the master modport is the environment/consumer.
interface dtc_master_rx_if;
  logic        dtc_data;
  logic        dtc_return;
  logic        rx_enable;
  logic [31:0] dout;
  logic        dout_last;
  logic        dout_valid;
  logic        dout_ready;
  logic        fifo_full;
  logic        busy;

  modport slave (
    input  dtc_data, dtc_return, rx_enable, dout_ready,
    output dout, dout_last, dout_valid, fifo_full, busy
  );

  modport master (
    output dtc_data, dtc_return, rx_enable, dout_ready,
    input  dout, dout_last, dout_valid, fifo_full, busy
  );
endinterface

// File: rtl/dtc_master_rx.sv
// Deframes 35-bit DTC readout frames into a first-word-fall-through FIFO and keeps saturating status counters.
// A word is visible the cycle after its stop bit; a push into a full FIFO with no same-cycle pop is dropped and counted.
module dtc_master_rx #(
  parameter int FIFO_AW = 2,
  parameter int CNT_W   = 16
) (
  input  logic             rdoclk,
  input  logic             resetn,
  dtc_master_rx_if.slave   rx,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] event_cnt,
  output logic [7:0]       perr_cnt,
  output logic [7:0]       ferr_cnt,
  output logic [7:0]       ovf_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_STOP} state_t;

  state_t state_q, state_d;

  logic [31:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             last_q, last_d;
  logic             perr_q, perr_d;

  logic [32:0]      mem_q [DEPTH];
  logic [32:0]      mem_d [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;

  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;
  logic [7:0]       perr_cnt_q, perr_cnt_d;
  logic [7:0]       ferr_cnt_q, ferr_cnt_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;

  logic busy;
  logic start_det;
  logic shift_en;
  logic par_en;
  logic stop_en;
  logic push_req;
  logic ferr_evt;
  logic perr_evt;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic ovf_evt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge rdoclk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rx.rx_enable && rx.dtc_data) state_d = S_SHIFT;
      S_SHIFT:  if (bit_cnt_q == 5'd31) state_d = S_PARITY;
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = 1'b1;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        start_det = rx.rx_enable & rx.dtc_data;
      end
      S_SHIFT:  shift_en = 1'b1;
      S_PARITY: par_en   = 1'b1;
      S_STOP:   stop_en  = 1'b1;
      default:  busy     = 1'b0;
    endcase
  end

  // ---------------- Deframing datapath ----------------
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    last_d    = last_q;
    perr_d    = perr_q;
    if (start_det) begin
      last_d    = rx.dtc_return;
      bit_cnt_d = '0;
    end
    if (shift_en) begin
      shift_d   = {shift_q[30:0], rx.dtc_data};
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
    // Odd parity: XOR over data plus parity bit must be 1.
    if (par_en) begin
      perr_d = ~(^shift_q ^ rx.dtc_data);
    end
  end

  // A high stop bit masks any parity verdict for the same frame.
  assign ferr_evt = stop_en & rx.dtc_data;
  assign perr_evt = stop_en & ~rx.dtc_data & perr_q;
  assign push_req = stop_en & ~rx.dtc_data & ~perr_q;

  always_ff @(posedge rdoclk) begin
    if (!resetn) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      perr_q    <= perr_d;
    end
  end

  // ---------------- FWFT FIFO ----------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = rx.dout_ready & ~fifo_empty;
  // A same-cycle pop frees the slot the push lands in.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign ovf_evt    = push_req & fifo_full & ~pop;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[FIFO_AW-1:0]] = {last_q, shift_q};
    end
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge rdoclk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge rdoclk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------- Saturating status counters ----------------
  always_comb begin
    word_cnt_d  = word_cnt_q;
    event_cnt_d = event_cnt_q;
    perr_cnt_d  = perr_cnt_q;
    ferr_cnt_d  = ferr_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (cnt_clr) begin
      word_cnt_d  = '0;
      event_cnt_d = '0;
      perr_cnt_d  = '0;
      ferr_cnt_d  = '0;
      ovf_cnt_d   = '0;
    end else begin
      if (push_ok && (word_cnt_q != '1))
        word_cnt_d = word_cnt_q + CNT_W'(1);
      if (push_ok && last_q && (event_cnt_q != '1))
        event_cnt_d = event_cnt_q + CNT_W'(1);
      if (perr_evt && (perr_cnt_q != 8'hFF))
        perr_cnt_d = perr_cnt_q + 8'd1;
      if (ferr_evt && (ferr_cnt_q != 8'hFF))
        ferr_cnt_d = ferr_cnt_q + 8'd1;
      if (ovf_evt && (ovf_cnt_q != 8'hFF))
        ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge rdoclk) begin
    if (!resetn) begin
      word_cnt_q  <= '0;
      event_cnt_q <= '0;
      perr_cnt_q  <= '0;
      ferr_cnt_q  <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      event_cnt_q <= event_cnt_d;
      perr_cnt_q  <= perr_cnt_d;
      ferr_cnt_q  <= ferr_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // ---------------- Outputs ----------------
  assign rx.dout       = mem_q[rd_ptr_q[FIFO_AW-1:0]][31:0];
  assign rx.dout_last  = mem_q[rd_ptr_q[FIFO_AW-1:0]][32];
  assign rx.dout_valid = ~fifo_empty;
  assign rx.fifo_full  = fifo_full;
  assign rx.busy       = busy;

  assign word_cnt  = word_cnt_q;
  assign event_cnt = event_cnt_q;
  assign perr_cnt  = perr_cnt_q;
  assign ferr_cnt  = ferr_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: doc/dtc_master_rx.md
# dtc_master_rx

Master-side DTC readout receiver for the FEE simulation environment. It sits directly downstream of the slave DTC's `dtc_data`/`dtc_return` outputs. It deframes the serial readout stream into 32-bit words with an end-of-event marker and buffers them in a small FIFO for the SRU-side consumer. It also keeps saturating word, event, parity-error, framing-error and overflow counters for the DCS status path.

## Interface
Parameters:
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW words (each 33 bits: data + last).
- `CNT_W`, 16: width of `word_cnt` and `event_cnt`.

Ports:
- `rdoclk`  in  1  single clock for the whole block.
- `resetn`  in  1  reset, synchronous, active-low.
- `dtc_data`  in  1  serial data line from the slave DTC, sampled every `rdoclk` edge.
- `dtc_return`  in  1  sampled during the start bit; 1 marks the word as last of event.
- `rx_enable`  in  1  allows the receiver to recognise new start bits.
- `dout`  out  32  head-of-FIFO data word.
- `dout_last`  out  1  head word is the last of its event.
- `dout_valid`  out  1  FIFO not empty.
- `dout_ready`  in  1  consumer pops the head word when `dout_valid & dout_ready`.
- `fifo_full`  out  1  FIFO holds 2^FIFO_AW words.
- `busy`  out  1  FSM is not in IDLE.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `word_cnt`  out  CNT_W  words accepted into the FIFO.
- `event_cnt`  out  CNT_W  accepted words with last=1.
- `perr_cnt`  out  8  parity errors.
- `ferr_cnt`  out  8  framing (stop-bit) errors.
- `ovf_cnt`  out  8  words dropped because the FIFO was full.

## Operation
- Line idles low. A frame is 35 bits, one per cycle, with no input register:
  - start bit = 1
  - 32 data bits, MSB first
  - parity bit: odd parity over data + parity
  - stop bit = 0
- FSM states and transitions:
  - IDLE: if `rx_enable & dtc_data`, latch `dtc_return` into the last flag, clear the bit counter, and go to SHIFT.
  - SHIFT: shift `dtc_data` into a 32-bit register. After the 32nd bit, go to PARITY.
  - PARITY: compute the parity check and go to STOP.
  - STOP: if `dtc_data` = 1, the frame has a framing error. Otherwise, if parity failed, the frame has a parity error. Otherwise push the word (see overflow rules below). Always return to IDLE.
- A frame with a framing error is dropped and `ferr_cnt` increments.
- A frame with a parity error is dropped and `perr_cnt` increments. A framing error takes precedence over a parity error; only `ferr_cnt` increments.
- The stop-cycle 1 is never reinterpreted as a start bit.
- `rx_enable` is checked only in IDLE. Deasserting it mid-frame lets the current frame complete.
- FIFO overflow rules:
  - A push while `fifo_full` with no pop in the same cycle drops the word and increments `ovf_cnt`.
  - A push while full with a simultaneous pop is accepted.
  - A pop while empty is ignored.
- FIFO is first-word-fall-through: `dout`/`dout_last` show the head entry whenever `dout_valid` = 1. `dout`/`dout_last` are don't-care when the FIFO is empty; the bench compares them only when `dout_valid` = 1.
- Pointers are FIFO_AW+1 bits wide and wrap naturally. Full = MSBs differ and LSBs equal.
- Counters saturate at all-ones.
  - `word_cnt` increments per accepted push.
  - `event_cnt` increments per accepted push with last=1.
  - `cnt_clr` clears all counters and wins over a same-cycle increment. It does not touch the FIFO or the FSM.

## Timing
- Reset (`resetn` = 0 at an edge):
  - FSM goes to IDLE; pointers and all counters go to 0.
  - `dout_valid`=0, `fifo_full`=0, `busy`=0.
  - Reset mid-frame discards the partial frame.
- Let cycle 0 be the start-bit cycle:
  - data bits occupy cycles 1..32 (bit31 at cycle 1);
  - parity occupies cycle 33;
  - stop occupies cycle 34.
- `busy` is high from cycle 1 through cycle 34.
- Push happens at the edge ending cycle 34. `dout_valid` and the counters update in cycle 35.
- The earliest next start bit is cycle 35. Back-to-back throughput is 1 word per 35 cycles.
- A pop at edge N removes the head word; the next entry is visible in cycle N+1.

## Test plan
- Single frame with data 0xDEADBEEF, parity 1 (24 ones + 1 = odd), `dtc_return`=1 at start -> `dout_valid` rises at cycle 35 with `dout`=0xDEADBEEF, `dout_last`=1; `word_cnt`=1, `event_cnt`=1.
- Frame with data 0x00000001 and parity bit 1 (even total) -> no push; `perr_cnt`=1, `dout_valid` stays 0. The next good frame is received normally.
- Frame with data 0x12345678 and stop bit 1 -> `ferr_cnt`=1. A start bit sent at cycle 35 is received correctly.
- `dout_ready`=0, six back-to-back good frames with FIFO_AW=2 -> 4 words stored, `fifo_full`=1, `ovf_cnt`=2. Then raise `dout_ready` -> words 1..4 pop in order.
- `resetn` low at cycle 20 of a frame -> all outputs reset. A fresh frame after release is received and `word_cnt`=1.
- `cnt_clr` asserted on the same cycle as a push -> `word_cnt`=0 afterward while the word is in the FIFO. Separately, `word_cnt` preset near all-ones stays at 0xFFFF after further frames.
